// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl
//   Stall/flush sequencer for the 5-stage MIPS pipeline. It compares the
//   operand demand of the instruction in D (Tuse) against the result
//   availability of the producers in E and M (Tnew). It also tracks a
//   multi-cycle mult/div unit so that HI/LO consumers in D wait for it.
//   While stalled, D is held (PC and F/D write enables low) and a bubble
//   is inserted into E (D/E clear). A saturating counter records how many
//   cycles were spent stalled.
//
// Ports
//   clk          pipeline clock, rising edge
//   reset        asynchronous, active-low reset
//   rs_D, rt_D   source register addresses of the instruction in D
//   tuse_rs_D    cycles until D needs rs (3 = never)
//   tuse_rt_D    cycles until D needs rt (3 = never)
//   a3_E, tnew_E destination and result latency of the instruction in E
//   a3_M, tnew_M destination and result latency of the instruction in M
//   md_use_D     D holds a HI/LO unit instruction
//   md_start_E   E issues mult/multu/div/divu this cycle
//   md_div_E     qualifies md_start_E: 1 = divide, 0 = multiply
//   pc_we        PC write enable
//   fd_we        F/D pipeline register write enable
//   de_clr       D/E pipeline register synchronous clear
//   md_busy      HI/LO unit busy (registered)
//   stall_cnt    saturating count of stall cycles since reset

module pipe_hazard_ctrl #(
    parameter int MULT_CYC = 5,
    parameter int DIV_CYC  = 10,
    parameter int CNT_W    = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       rs_D,
    input  logic [4:0]       rt_D,
    input  logic [1:0]       tuse_rs_D,
    input  logic [1:0]       tuse_rt_D,
    input  logic [4:0]       a3_E,
    input  logic [1:0]       tnew_E,
    input  logic [4:0]       a3_M,
    input  logic [1:0]       tnew_M,
    input  logic             md_use_D,
    input  logic             md_start_E,
    input  logic             md_div_E,
    output logic             pc_we,
    output logic             fd_we,
    output logic             de_clr,
    output logic             md_busy,
    output logic [CNT_W-1:0] stall_cnt
);

    // The busy timer must hold the longer of the two latencies, but never
    // narrower than 4 bits.
    localparam int MAX_CYC = (MULT_CYC > DIV_CYC) ? MULT_CYC : DIV_CYC;
    localparam int CW_RAW  = $clog2(MAX_CYC + 1);
    localparam int CW      = (CW_RAW < 4) ? 4 : CW_RAW;

    localparam logic [CW-1:0]    MULT_LOAD = CW'(MULT_CYC);
    localparam logic [CW-1:0]    DIV_LOAD  = CW'(DIV_CYC);
    localparam logic [CW-1:0]    CNT_ONE   = CW'(1);
    localparam logic [CNT_W-1:0] STALL_ONE = CNT_W'(1);

    logic [CW-1:0] md_cnt;
    logic [CW-1:0] md_cnt_nxt;
    logic          stall_rs;
    logic          stall_rt;
    logic          stall_md;
    logic          stall;

    // Register hazards: a producer stalls D only when its result arrives
    // later than D needs it. Tuse = 3 can never be exceeded by a 2-bit
    // Tnew, so an unused operand never stalls; $zero is never a hazard.
    always_comb begin
        stall_rs = (rs_D != 5'd0) &&
                   (((rs_D == a3_E) && (tnew_E > tuse_rs_D)) ||
                    ((rs_D == a3_M) && (tnew_M > tuse_rs_D)));
        stall_rt = (rt_D != 5'd0) &&
                   (((rt_D == a3_E) && (tnew_E > tuse_rt_D)) ||
                    ((rt_D == a3_M) && (tnew_M > tuse_rt_D)));
        // An issue in E this cycle counts as busy even before md_busy rises.
        stall_md = md_use_D && (md_start_E || md_busy);
        stall    = stall_rs || stall_rt || stall_md;
    end

    // Hold D and inject a bubble into E; later stages keep flowing.
    always_comb begin
        pc_we  = ~stall;
        fd_we  = ~stall;
        de_clr = stall;
    end

    // Next busy-timer value: a new issue always reloads (newest wins),
    // otherwise count down to zero.
    always_comb begin
        md_cnt_nxt = md_cnt;
        if (md_start_E) begin
            md_cnt_nxt = md_div_E ? DIV_LOAD : MULT_LOAD;
        end else if (md_cnt != '0) begin
            md_cnt_nxt = md_cnt - CNT_ONE;
        end
    end

    // md_busy is registered from the next count so it is high for exactly
    // the programmed number of cycles after the issuing edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            md_cnt  <= '0;
            md_busy <= 1'b0;
        end else begin
            md_cnt  <= md_cnt_nxt;
            md_busy <= (md_cnt_nxt != '0);
        end
    end

    // Stall performance counter; sticks at all-ones instead of wrapping.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt <= '0;
        end else if (stall && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + STALL_ONE;
        end
    end

endmodule
